// File: rtl/dm_unit_pkg.sv
// rtl/dm_unit_pkg.sv - shared encodings and store-lane helpers for the data-memory unit
//
// Holds the DMWr/DMRe control codes driven by the control unit, the
// DM_IDLE/DM_ACCESS/DM_WAIT/DM_DONE state encodings, the latched request
// record and the byte-enable / lane-replication helpers.
package dm_unit_pkg;

    typedef enum logic [1:0] {
        DMWR_NOP = 2'd0,
        DMWR_SB  = 2'd1,
        DMWR_SH  = 2'd2,
        DMWR_SW  = 2'd3
    } dmwr_t;

    typedef enum logic [2:0] {
        DMRE_NOP = 3'd0,
        DMRE_LB  = 3'd1,
        DMRE_LBU = 3'd2,
        DMRE_LH  = 3'd3,
        DMRE_LHU = 3'd4,
        DMRE_LW  = 3'd5
    } dmre_t;

    typedef enum logic [1:0] {
        DM_IDLE   = 2'd0,
        DM_ACCESS = 2'd1,
        DM_WAIT   = 2'd2,
        DM_DONE   = 2'd3
    } dm_state_t;

    // Request captured in IDLE and held until the access retires.
    typedef struct packed {
        logic       store;  // 1: store, 0: load
        dmre_t      re;     // load code, DMRE_NOP for stores
        logic [1:0] off;    // byte offset after alignment forcing
        logic       trap;   // misaligned access suppressed (trap build only)
    } dm_req_t;

    // Byte enables for a store; bit i selects little-endian byte lane i.
    function automatic logic [3:0] store_be(dmwr_t wr, logic [1:0] off);
        case (wr)
            DMWR_SB: return 4'b0001 << off;
            DMWR_SH: return off[1] ? 4'b1100 : 4'b0011;
            DMWR_SW: return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    // Replicate the store datum across lanes so the enables alone pick the target.
    function automatic logic [31:0] store_lanes(dmwr_t wr, logic [31:0] d);
        case (wr)
            DMWR_SB: return {4{d[7:0]}};
            DMWR_SH: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/dm_unit_if.sv
// rtl/dm_unit_if.sv - word-wide synchronous SRAM port of the data-memory unit
//
// master: dm_unit side (drives mem_en/mem_we/mem_be/mem_addr/mem_wdata, reads mem_rdata)
// slave : SRAM side   (reverse directions)
interface dm_unit_if #(
    parameter int AW = 10
);
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport master (
        output mem_en,
        output mem_we,
        output mem_be,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_be,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dm_lane_ext.sv
// rtl/dm_lane_ext.sv - load lane select with sign/zero extension
//
// Ports:
//   word   in  32  raw SRAM word
//   off    in  2   byte offset within the word (already aligned for halves/words)
//   op     in  3   load code (DMRE_*)
//   result out 32  extracted and extended value
module dm_lane_ext
    import dm_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  dmre_t       op,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*off +: 8];
        half_sel = off[1] ? word[31:16] : word[15:0];
        case (op)
            DMRE_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            DMRE_LBU: result = {24'h0, byte_sel};
            DMRE_LH:  result = {{16{half_sel[15]}}, half_sel};
            DMRE_LHU: result = {16'h0, half_sel};
            default:  result = word;
        endcase
    end

endmodule

// File: rtl/dm_unit.sv
// rtl/dm_unit.sv - data-memory responder for the MIPS MEM stage
//
// Optional feature macro: DM_MISALIGN_TRAP_EN (sticky misalign flag, suppresses
// the SRAM access of misaligned half/word operations; loads then return 0).
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   DMWr       in   2   store code (DMWR_*)
//   DMRe       in   3   load code (DMRE_*)
//   addr       in   32  byte address from the ALU
//   wdata      in   32  store data (rt)
//   rdata      out  32  extended load result, valid with done, held until next load
//   stall      out  1   hold the pipeline while an access is in flight
//   done       out  1   one-cycle completion pulse
//   misalign   out  1   sticky misaligned-access flag (0 without the feature)
//   mem        master   SRAM port (dm_unit_if)
module dm_unit
    import dm_unit_pkg::*;
#(
    parameter int AW     = 10,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  DMWr,
    input  logic [2:0]  DMRe,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        misalign,
    dm_unit_if.master   mem
);

    dm_state_t   state;
    dm_req_t     req_q;
    logic [2:0]  cnt;
    logic [31:0] rdata_q;
    logic [31:0] ext_data;

    dmwr_t       wr_c;
    dmre_t       re_c;
    logic        is_store;
    logic        req;
    logic        byte_acc;
    logic        half_acc;
    logic        word_acc;
    logic        trap_req;
    logic [1:0]  off_eff;

    // Memory aliases: address bits above the SRAM word range are ignored.
    logic        unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

    assign wr_c     = dmwr_t'(DMWr);
    assign re_c     = dmre_t'(DMRe);
    assign is_store = (wr_c != DMWR_NOP);
    assign req      = is_store || (re_c != DMRE_NOP);

    // Access size; a store wins over a simultaneous load code.
    always_comb begin
        byte_acc = is_store ? (wr_c == DMWR_SB) : (re_c == DMRE_LB || re_c == DMRE_LBU);
        half_acc = is_store ? (wr_c == DMWR_SH) : (re_c == DMRE_LH || re_c == DMRE_LHU);
        word_acc = !byte_acc && !half_acc;
        if (word_acc)
            off_eff = 2'b00;
        else if (half_acc)
            off_eff = {addr[1], 1'b0};
        else
            off_eff = addr[1:0];
    end

`ifdef DM_MISALIGN_TRAP_EN
    logic mis_req;
    assign mis_req  = (half_acc && addr[0]) || (word_acc && (addr[1:0] != 2'b00));
    assign trap_req = mis_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign <= 1'b0;
        else if (state == DM_IDLE && req && mis_req)
            misalign <= 1'b1;
    end
`else
    assign trap_req = 1'b0;
    assign misalign = 1'b0;
`endif

    assign stall = (state == DM_IDLE && req) || state == DM_ACCESS || state == DM_WAIT;

    dm_lane_ext u_lane_ext (
        .word   (mem.mem_rdata),
        .off    (req_q.off),
        .op     (req_q.re),
        .result (ext_data)
    );

    // In DONE the SRAM word is on mem_rdata, so the result is presented
    // directly alongside done and registered for the following cycles.
    assign rdata = (state == DM_DONE && !req_q.store) ? (req_q.trap ? 32'h0 : ext_data)
                                                      : rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= DM_IDLE;
            req_q         <= '0;
            cnt           <= 3'd0;
            rdata_q       <= 32'h0;
            done          <= 1'b0;
            mem.mem_en    <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_be    <= 4'h0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= 32'h0;
        end else begin
            done       <= 1'b0;
            mem.mem_en <= 1'b0;
            mem.mem_we <= 1'b0;
            case (state)
                DM_IDLE: begin
                    if (req) begin
                        req_q.store  <= is_store;
                        req_q.re     <= is_store ? DMRE_NOP : re_c;
                        req_q.off    <= off_eff;
                        req_q.trap   <= trap_req;
                        mem.mem_addr <= addr[AW+1:2];
                        mem.mem_en   <= !trap_req;
                        mem.mem_we   <= is_store && !trap_req;
                        if (is_store) begin
                            mem.mem_be    <= store_be(wr_c, off_eff);
                            mem.mem_wdata <= store_lanes(wr_c, wdata);
                        end else begin
                            mem.mem_be    <= 4'hF;
                        end
                        state <= DM_ACCESS;
                    end
                end
                DM_ACCESS: begin
                    if (req_q.store || RD_LAT == 1) begin
                        done  <= 1'b1;
                        state <= DM_DONE;
                    end else begin
                        cnt   <= 3'(RD_LAT - 1);
                        state <= DM_WAIT;
                    end
                end
                DM_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        done  <= 1'b1;
                        state <= DM_DONE;
                    end
                end
                DM_DONE: begin
                    if (!req_q.store)
                        rdata_q <= req_q.trap ? 32'h0 : ext_data;
                    state <= DM_IDLE;
                end
                default: state <= DM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_unit.sv
// tb/tb_dm_unit.sv - self-checking bench for dm_unit (RD_LAT=1 and RD_LAT=3 instances)
module tb_dm_unit;
    import dm_unit_pkg::*;

    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    wr_in [2];
    logic [2:0]    re_in [2];
    logic [31:0]   a_in  [2];
    logic [31:0]   wd_in [2];
    logic [31:0]   rd_out [2];
    logic          stall_o [2];
    logic          done_o [2];
    logic          mis_o [2];
    logic          en [2];
    logic          we [2];
    logic [3:0]    be [2];
    logic [AW-1:0] maddr [2];
    logic [31:0]   mwd [2];
    logic [31:0]   rd_bus [2];

    dm_unit_if #(.AW(AW)) mif0 ();
    dm_unit_if #(.AW(AW)) mif1 ();

    dm_unit #(.AW(AW), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .DMWr(wr_in[0]), .DMRe(re_in[0]), .addr(a_in[0]),
        .wdata(wd_in[0]), .rdata(rd_out[0]), .stall(stall_o[0]), .done(done_o[0]),
        .misalign(mis_o[0]), .mem(mif0)
    );

    dm_unit #(.AW(AW), .RD_LAT(3)) u_dut1 (
        .clk(clk), .rst(rst), .DMWr(wr_in[1]), .DMRe(re_in[1]), .addr(a_in[1]),
        .wdata(wd_in[1]), .rdata(rd_out[1]), .stall(stall_o[1]), .done(done_o[1]),
        .misalign(mis_o[1]), .mem(mif1)
    );

    assign en[0] = mif0.mem_en;    assign en[1] = mif1.mem_en;
    assign we[0] = mif0.mem_we;    assign we[1] = mif1.mem_we;
    assign be[0] = mif0.mem_be;    assign be[1] = mif1.mem_be;
    assign maddr[0] = mif0.mem_addr;  assign maddr[1] = mif1.mem_addr;
    assign mwd[0] = mif0.mem_wdata;   assign mwd[1] = mif1.mem_wdata;
    assign mif0.mem_rdata = rd_bus[0];
    assign mif1.mem_rdata = rd_bus[1];

    // SRAM models: data valid exactly LAT cycles after the mem_en cycle, garbage otherwise.
    for (genvar k = 0; k < 2; k++) begin : g_sram
        localparam int LAT = (k == 0) ? 1 : 3;
        logic [31:0] mem [1024];
        logic [31:0] pipe [LAT];
        always @(posedge clk) begin
            if (mem_clr) begin
                for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            end else if (en[k] && we[k]) begin
                for (int j = 0; j < 4; j++)
                    if (be[k][j]) mem[maddr[k]][8*j +: 8] <= mwd[k][8*j +: 8];
            end
            pipe[0] <= (en[k] && !we[k]) ? mem[maddr[k]] : 32'hBAD0BAD0;
            for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
        end
        assign rd_bus[k] = pipe[LAT-1];
    end

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  ref_mem [2][4096];
    logic [31:0] last_rd [2];
    logic        mis_exp [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input int u);
        check($sformatf("rst_rdata_u%0d", u), rd_out[u], 32'h0);
        check($sformatf("rst_done_u%0d", u), done_o[u], 0);
        check($sformatf("rst_stall_u%0d", u), stall_o[u], 0);
        check($sformatf("rst_en_u%0d", u), en[u], 0);
        check($sformatf("rst_we_u%0d", u), we[u], 0);
        check($sformatf("rst_be_u%0d", u), be[u], 0);
        check($sformatf("rst_addr_u%0d", u), maddr[u], 0);
        check($sformatf("rst_wdata_u%0d", u), mwd[u], 0);
        check($sformatf("rst_mis_u%0d", u), mis_o[u], 0);
    endtask

    // Issue one access, follow it to done, and compare against the byte-array model.
    task automatic run_op(input int u, input logic [1:0] wr, input logic [2:0] re,
                          input logic [31:0] a, input logic [31:0] wd);
        int lat, st, en_n, sz, rl;
        bit got, store, trapped, sgn;
        logic [3:0]    be_s, be_e;
        logic [AW-1:0] ad_s;
        logic [31:0]   wd_s, rd_s, base, v, wd_e;
        logic          we_s;
        logic [11:0]   b;

        store = (wr != 2'd0);
        rl    = (u == 0) ? 1 : 3;
        sgn   = 0;
        if (store) begin
            sz = (wr == 2'd1) ? 1 : (wr == 2'd2) ? 2 : 4;
        end else begin
            case (re)
                3'd1: begin sz = 1; sgn = 1; end
                3'd2: sz = 1;
                3'd3: begin sz = 2; sgn = 1; end
                3'd4: sz = 2;
                default: sz = 4;
            endcase
        end
`ifdef DM_MISALIGN_TRAP_EN
        trapped = (a & 32'(sz - 1)) != 0;
`else
        trapped = 0;
`endif
        base = a & ~32'(sz - 1);
        b    = base[11:0];

        wr_in[u] = wr; re_in[u] = re; a_in[u] = a; wd_in[u] = wd;
        lat = 0; st = 0; en_n = 0; got = 0;
        be_s = '0; ad_s = '0; wd_s = '0; we_s = 0; rd_s = '0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (stall_o[u]) st++;
            if (en[u]) begin
                en_n++; be_s = be[u]; ad_s = maddr[u]; wd_s = mwd[u]; we_s = we[u];
            end
            if (done_o[u]) begin
                got  = 1;
                rd_s = rd_out[u];
            end else begin
                @(posedge clk); #1;
            end
        end
        check($sformatf("done_seen_u%0d", u), got, 1);
        @(posedge clk); #1;
        wr_in[u] = 2'd0; re_in[u] = 3'd0;

        check($sformatf("latency_u%0d", u), lat, store ? 3 : 2 + rl);
        check($sformatf("stall_cycles_u%0d", u), st, store ? 2 : 1 + rl);
        check($sformatf("en_cycles_u%0d", u), en_n, trapped ? 0 : 1);
        if (!trapped && en_n == 1) begin
            be_e = store ? 4'(((1 << sz) - 1) << base[1:0]) : 4'hF;
            wd_e = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
            check($sformatf("be_u%0d", u), be_s, be_e);
            check($sformatf("maddr_u%0d", u), ad_s, a[AW+1:2]);
            check($sformatf("we_u%0d", u), we_s, store);
            if (store) check($sformatf("wdata_u%0d", u), wd_s, wd_e);
        end

        if (store) begin
            if (!trapped)
                for (int i = 0; i < sz; i++) ref_mem[u][b + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            if (!trapped) begin
                for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[u][b + i];
                if (sgn) v = $signed(v << (32 - 8*sz)) >>> (32 - 8*sz);
            end
            last_rd[u] = v;
            check($sformatf("rdata_at_done_u%0d", u), rd_s, v);
        end
        mis_exp[u] = mis_exp[u] | trapped;
        check($sformatf("misalign_u%0d", u), mis_o[u], mis_exp[u]);
        check($sformatf("rdata_hold_u%0d", u), rd_out[u], last_rd[u]);
        check($sformatf("done_low_u%0d", u), done_o[u], 0);
    endtask

    task automatic rand_op(input int u);
        logic [1:0]  wr;
        logic [2:0]  re;
        logic [31:0] a;
        a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
        re = 3'($urandom_range(1, 5));
        wr = 2'd0;
        if ($urandom_range(0, 1) == 1) begin
            wr = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 2) != 0) re = 3'd0;
        end
        run_op(u, wr, re, a, $urandom);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            wr_in[u] = 2'd0; re_in[u] = 3'd0; a_in[u] = 32'h0; wd_in[u] = 32'h0;
            last_rd[u] = 32'h0; mis_exp[u] = 1'b0;
            for (int i = 0; i < 4096; i++) ref_mem[u][i] = 8'h0;
        end
        rst = 1'b1; mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        @(negedge clk);
        rst = 1'b0; mem_clr = 1'b0;
        @(posedge clk); #1;

        run_op(0, DMWR_SW, DMRE_NOP, 32'h10, 32'hDEADBEEF);
        run_op(0, DMWR_NOP, DMRE_LW, 32'h10, 32'h0);
        run_op(0, DMWR_SB, DMRE_NOP, 32'h13, 32'h000000A5);
        run_op(0, DMWR_NOP, DMRE_LB, 32'h13, 32'h0);
        run_op(0, DMWR_NOP, DMRE_LBU, 32'h13, 32'h0);
        run_op(0, DMWR_SH, DMRE_NOP, 32'h22, 32'h00008001);
        run_op(0, DMWR_NOP, DMRE_LH, 32'h22, 32'h0);
        run_op(0, DMWR_NOP, DMRE_LHU, 32'h22, 32'h0);
        run_op(0, DMWR_SW, DMRE_LW, 32'h8000_0020, 32'h1234_C0DE);
        run_op(0, DMWR_NOP, DMRE_LH, 32'h21, 32'h0);
        run_op(0, DMWR_NOP, DMRE_LW, 32'h0000_1020, 32'h0);

        run_op(1, DMWR_SW, DMRE_NOP, 32'h10, 32'hDEADBEEF);
        run_op(1, DMWR_NOP, DMRE_LW, 32'h10, 32'h0);
        run_op(1, DMWR_NOP, DMRE_LB, 32'h13, 32'h0);

        // Reset while the RD_LAT=3 unit sits in WAIT.
        wr_in[1] = 2'd0; re_in[1] = DMRE_LW; a_in[1] = 32'h10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("stall_in_wait", stall_o[1], 1);
        #2;
        rst = 1'b1; re_in[1] = 3'd0;
        #1;
        check_reset(1);
        check_reset(0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int u = 0; u < 2; u++) begin
            last_rd[u] = 32'h0; mis_exp[u] = 1'b0;
        end
        run_op(1, DMWR_NOP, DMRE_LW, 32'h10, 32'h0);

        for (int n = 0; n < 40; n++) rand_op(0);
        for (int n = 0; n < 20; n++) rand_op(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
- Data-memory responder for the MIPS datapath; the memory-side end of the control unit's DMWr/DMRe interface.
- Accepts one load or store per instruction from the MEM stage: ALU address, rt store data, and the DMWr/DMRe codes.
- Drives a word-wide synchronous SRAM with byte enables, and stalls the core until the access completes.
- On loads, returns the byte/half/word extracted, then sign- or zero-extended.

Parameters:
AW, 10, SRAM word-address width (memory = 2^AW words).
RD_LAT, 1, SRAM read latency in cycles from the mem_en cycle to mem_rdata valid (range 1..7).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
DMWr  in  2  store code: DMWR_NOP/SB/SH/SW
DMRe  in  3  load code: DMRE_NOP/LB/LBU/LH/LHU/LW
addr  in  32  byte address from ALU
wdata  in  32  store data (rt)
rdata  out  32  extended load result
stall  out  1  core must hold PC/pipeline and keep inputs stable
done  out  1  one-cycle pulse: access complete, rdata valid for loads
mem_en  out  1  SRAM access strobe
mem_we  out  1  SRAM write
mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
mem_addr  out  AW  word address = addr[AW+1:2]
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  SRAM read data
misalign  out  1  sticky misaligned-access flag (only with feature)

Behaviour:
- Reset: state IDLE; rdata=0, done=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, misalign=0, latch/counter cleared.
- Reset mid-operation aborts the access immediately; no SRAM write completes after rst asserts.
- Request: req = (DMWr!=NOP)|(DMRe!=NOP). If both are non-NOP, the store is performed and the load code is ignored.
- stall = (state==IDLE & req) | state==ACCESS | state==WAIT. stall is low in DONE and in IDLE with no request.
- FSM:
  - IDLE: on req, latch op, addr[1:0], wdata, mem_addr → ACCESS.
  - ACCESS: mem_en=1 for exactly one cycle.
    - Store: mem_we=1, lanes per code → DONE.
    - Load: mem_we=0, mem_be=4'hF; counter=RD_LAT-1; if RD_LAT==1 → DONE, else → WAIT.
  - WAIT: decrement counter; at 0 → DONE.
  - DONE: done=1; loads capture mem_rdata, extract lane by latched addr[1:0], extend, and register into rdata. rdata then holds until the next load's DONE. Inputs are ignored in DONE → IDLE.
- Latency:
  - Store: 3 cycles (request→ACCESS→DONE), stall high for 2.
  - Load: 2+RD_LAT cycles.
- Byte enables:
  - SB: 1<<addr[1:0].
  - SH: addr[1]?4'b1100:4'b0011.
  - SW: 4'hF.
- mem_wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load extraction: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW whole word.
- Address wrap: bits above AW+1 are ignored (memory aliases).
- Misalignment (feature off): SH/LH/LHU ignore addr[0]; SW/LW ignore addr[1:0].

Optional Feature:
- DM_MISALIGN_TRAP_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, sets misalign (sticky until rst). The FSM still runs to DONE with identical latency, but mem_en stays 0 and loads return rdata=0.
- Undefined: misalign is tied 0 and low bits are forced aligned as above.

Decomposition:
- DMWR_*/DMRE_* codes stay in shared ctrl_encode_def.v.
- Add DM_IDLE/DM_ACCESS/DM_WAIT/DM_DONE state encodings there.
- One sub-module, dm_lane_ext: combinational lane select plus sign/zero extension, reused by the bench model.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 with RD_LAT=1 → mem_be=F on write; done 3 cycles after the load request; rdata=0xDEADBEEF.
- SB 0x13 wdata=0x000000A5, then LB 0x13 and LBU 0x13 → mem_be=4'b1000; rdata=0xFFFFFFA5 then 0x000000A5.
- SH 0x22 wdata=0x00008001, then LH 0x22 and LHU 0x22 → mem_be=4'b1100; rdata=0xFFFF8001 then 0x00008001.
- RD_LAT=3, LW → stall high exactly 4 cycles, done pulses once, mem_en high exactly 1 cycle.
- rst asserted during WAIT → all outputs return to reset values immediately; next LW completes normally.
- LH 0x21 with DM_MISALIGN_TRAP_EN → misalign=1, mem_en never asserts, rdata=0; without the macro → reads half at 0x20.
